// File: rtl/uart_tx_arb.sv
`default_nettype none
// =============================================================================
// Module : uart_tx_arb
// Round-robin packet arbiter sharing a single uart_tx byte buffer among requesters.
// Rev    : 1.0
// =============================================================================

module uart_tx_arb #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic                 tx_full_i,
    output logic [7:0]           tx_data_o,
    output logic                 tx_write_o,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int          IDX_W      = $clog2(NUM_REQ);
    localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYC - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   last_grant_nxt;
    logic [15:0]        idle_cnt;
    logic [15:0]        idle_cnt_nxt;
    logic               timeout_nxt;

    logic [IDX_W-1:0]   gidx;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic               win_found;
    logic               valid_g;
    logic               accept;
    logic               accept_last;

    // Owner index and byte mux; data reads zero whenever nobody holds the grant.
    always_comb begin
        gidx      = '0;
        tx_data_o = 8'h00;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant_o[k]) begin
                gidx      = IDX_W'(k);
                tx_data_o = req_data_i[8*k +: 8];
            end
        end
    end

    assign req_ready_o = (state == XFER && !tx_full_i) ? grant_o : '0;
    assign tx_write_o  = |(req_valid_i & req_ready_o);
    assign accept      = tx_write_o;
    assign valid_g     = req_valid_i[gidx];
    assign accept_last = accept & req_last_i[gidx];
    assign busy_o      = (state == XFER);

    // Search starts one past the previous owner; the final pass (i = NUM_REQ)
    // wraps back onto the previous owner itself.
    always_comb begin
        winner    = last_grant;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = last_grant + IDX_W'(i);
            if (!win_found && req_valid_i[cand]) begin
                winner    = cand;
                win_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_o;
        last_grant_nxt = last_grant;
        idle_cnt_nxt   = idle_cnt;
        timeout_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    state_nxt         = XFER;
                    grant_nxt         = '0;
                    grant_nxt[winner] = 1'b1;
                    last_grant_nxt    = winner;
                    idle_cnt_nxt      = '0;
                end
            end
            XFER: begin
                if (accept) begin
                    idle_cnt_nxt = '0;
                    if (accept_last) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end else if (!valid_g) begin
                    // A stalled owner is only charged for cycles it has nothing to offer.
                    if (idle_cnt == IDLE_LIMIT) begin
                        timeout_nxt  = 1'b1;
                        state_nxt    = IDLE;
                        grant_nxt    = '0;
                        idle_cnt_nxt = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 16'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant_o    <= '0;
            last_grant <= IDX_W'(NUM_REQ - 1);
            idle_cnt   <= '0;
            timeout_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant_o    <= grant_nxt;
            last_grant <= last_grant_nxt;
            idle_cnt   <= idle_cnt_nxt;
            timeout_o  <= timeout_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// Testbench for uart_tx_arb: arbitration vector table plus scoreboarded packet sequences.

module tb_uart_tx_arb;

    localparam logic [31:0] DATA = 32'hA3A2A1A0;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid_i;
    logic [31:0] req_data_i;
    logic [3:0]  req_last_i;
    logic [3:0]  req_ready_o;
    logic        tx_full_i;
    logic [7:0]  tx_data_o;
    logic        tx_write_o;
    logic [3:0]  grant_o;
    logic        busy_o;
    logic        timeout_o;

    uart_tx_arb #(
        .NUM_REQ     (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid_i),
        .req_data_i  (req_data_i),
        .req_last_i  (req_last_i),
        .req_ready_o (req_ready_o),
        .tx_full_i   (tx_full_i),
        .tx_data_o   (tx_data_o),
        .tx_write_o  (tx_write_o),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        int         pre;
        logic [3:0] valid;
        logic       full;
        logic [3:0] exp_grant;
        logic [3:0] exp_ready;
        logic       exp_write;
        logic [7:0] exp_data;
    } vec_t;

    vec_t        vec [7];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          to_cnt = 0;
    int          to_cyc = 0;
    logic [3:0]  to_grant;
    logic [3:0]  acc;
    logic        bfm_on = 1'b0;
    logic        sb_en = 1'b0;
    logic [8:0]  src [4][$];
    logic [11:0] exp_q [$];
    int          wr_cyc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_srcs();
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        v = '0;
        l = '0;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            if (src[k].size() > 0) begin
                v[k]       = 1'b1;
                l[k]       = src[k][0][8];
                d[8*k +: 8] = src[k][0][7:0];
            end
        end
        req_valid_i = v;
        req_last_i  = l;
        req_data_i  = d;
    endtask

    // Outputs are sampled on the falling edge; inputs change just after the rising edge.
    task automatic step();
        @(negedge clk);
        acc = req_valid_i & req_ready_o;
        if (tx_write_o) begin
            wr_cyc.push_back(cyc);
            chk("no_write_while_full", 32'(tx_full_i), 32'd0);
            if (sb_en) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected_write: got grant=%b data=0x%h, required no write",
                             grant_o, tx_data_o);
                end else begin
                    chk("sb_write_grant_data", 32'({grant_o, tx_data_o}), 32'(exp_q.pop_front()));
                end
            end
        end
        if (timeout_o) begin
            to_cnt++;
            to_cyc   = cyc;
            to_grant = grant_o;
        end
        @(posedge clk);
        cyc++;
        #1;
        if (bfm_on) begin
            for (int k = 0; k < 4; k++)
                if (acc[k] && src[k].size() > 0) void'(src[k].pop_front());
            drive_srcs();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) src[k].delete();
        exp_q.delete();
        req_valid_i = '0;
        req_data_i  = '0;
        req_last_i  = '0;
        tx_full_i   = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        wr_cyc.delete();
        to_cnt = 0;
    endtask

    task automatic expect_wr(input logic [3:0] g, input logic [7:0] d);
        exp_q.push_back({g, d});
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        vec[0] = '{-1, 4'b1010, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'hA1};
        vec[1] = '{-1, 4'b1111, 1'b1, 4'b0001, 4'b0000, 1'b0, 8'hA0};
        vec[2] = '{ 0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'hA0};
        vec[3] = '{ 1, 4'b1011, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'hA3};
        vec[4] = '{ 3, 4'b1100, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA2};
        vec[5] = '{ 2, 4'b0110, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'hA1};
        vec[6] = '{ 1, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0, 8'hA2};

        rst_n       = 1'b0;
        req_valid_i = 4'hF;
        req_data_i  = DATA;
        req_last_i  = 4'hF;
        tx_full_i   = 1'b0;
        step();
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        chk("rst_write", 32'(tx_write_o), 32'd0);
        chk("rst_data", 32'(tx_data_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            if (vec[i].pre >= 0) begin
                req_valid_i = 4'b0001 << vec[i].pre;
                req_last_i  = 4'b0001 << vec[i].pre;
                req_data_i  = DATA;
                step();
                step();
                req_valid_i = '0;
                req_last_i  = '0;
            end
            req_valid_i = vec[i].valid;
            req_last_i  = '0;
            req_data_i  = DATA;
            tx_full_i   = vec[i].full;
            #1;
            chk("vec_idle_ready", 32'(req_ready_o), 32'd0);
            chk("vec_idle_write", 32'(tx_write_o), 32'd0);
            step();
            chk("vec_grant", 32'(grant_o), 32'(vec[i].exp_grant));
            chk("vec_busy", 32'(busy_o), 32'd1);
            chk("vec_ready", 32'(req_ready_o), 32'(vec[i].exp_ready));
            chk("vec_write", 32'(tx_write_o), 32'(vec[i].exp_write));
            chk("vec_data", 32'(tx_data_o), 32'(vec[i].exp_data));
            tx_full_i  = 1'b0;
            req_last_i = 4'hF;
            step();
            req_valid_i = '0;
            req_last_i  = '0;
            #1;
            chk("vec_release_grant", 32'(grant_o), 32'd0);
            chk("vec_release_busy", 32'(busy_o), 32'd0);
        end

        bfm_on = 1'b1;
        sb_en  = 1'b1;

        // Requester 1 first (lowest valid after reset), then 3.
        do_reset();
        src[1].push_back({1'b0, 8'h11});
        src[1].push_back({1'b1, 8'h12});
        src[3].push_back({1'b1, 8'h31});
        expect_wr(4'b0010, 8'h11);
        expect_wr(4'b0010, 8'h12);
        expect_wr(4'b1000, 8'h31);
        drive_srcs();
        step();
        chk("s1_first_grant", 32'(grant_o), 32'b0010);
        drain("s1", 30);

        // Four continuous single-byte streams: strict rotation, one idle cycle per packet.
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) begin
                src[k].push_back({1'b1, 8'(16 * k + r)});
                expect_wr(4'b0001 << k, 8'(16 * k + r));
            end
        drive_srcs();
        drain("s2", 60);
        chk("s2_write_count", 32'(wr_cyc.size()), 32'd8);
        for (int i = 1; i < wr_cyc.size(); i++)
            chk("s2_write_spacing", 32'(wr_cyc[i] - wr_cyc[i-1]), 32'd2);

        // Back-pressure mid-packet: 5 and then 12 full cycles, longer than the timeout.
        do_reset();
        src[0].push_back({1'b0, 8'h41});
        src[0].push_back({1'b0, 8'h42});
        src[0].push_back({1'b1, 8'h43});
        expect_wr(4'b0001, 8'h41);
        expect_wr(4'b0001, 8'h42);
        expect_wr(4'b0001, 8'h43);
        drive_srcs();
        step();
        step();
        tx_full_i = 1'b1;
        #1;
        chk("s3_ready_while_full", 32'(req_ready_o), 32'd0);
        chk("s3_write_while_full", 32'(tx_write_o), 32'd0);
        repeat (5) step();
        tx_full_i = 1'b0;
        step();
        tx_full_i = 1'b1;
        repeat (12) step();
        tx_full_i = 1'b0;
        drain("s3", 10);
        chk("s3_write_count", 32'(wr_cyc.size()), 32'd3);
        chk("s3_no_timeout", 32'(to_cnt), 32'd0);

        // Owner 0 stalls after one byte: eight idle cycles, then the registered pulse.
        do_reset();
        src[0].push_back({1'b0, 8'h50});
        src[1].push_back({1'b1, 8'h60});
        expect_wr(4'b0001, 8'h50);
        expect_wr(4'b0010, 8'h60);
        drive_srcs();
        drain("s4", 40);
        chk("s4_timeout_count", 32'(to_cnt), 32'd1);
        if (wr_cyc.size() > 0)
            chk("s4_timeout_latency", 32'(to_cyc - wr_cyc[0]), 32'd9);
        chk("s4_grant_at_timeout", 32'(to_grant), 32'd0);

        // Reset in the middle of requester 2's packet.
        do_reset();
        src[2].push_back({1'b0, 8'h70});
        src[2].push_back({1'b0, 8'h71});
        src[2].push_back({1'b1, 8'h72});
        expect_wr(4'b0100, 8'h70);
        drive_srcs();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_rst_grant", 32'(grant_o), 32'd0);
        chk("s5_rst_ready", 32'(req_ready_o), 32'd0);
        chk("s5_rst_write", 32'(tx_write_o), 32'd0);
        chk("s5_rst_data", 32'(tx_data_o), 32'd0);
        chk("s5_rst_busy", 32'(busy_o), 32'd0);
        chk("s5_first_byte_sent", 32'(exp_q.size()), 32'd0);
        step();
        for (int k = 0; k < 4; k++) src[k].delete();
        step();
        rst_n = 1'b1;
        src[0].push_back({1'b1, 8'h80});
        src[2].push_back({1'b1, 8'h90});
        expect_wr(4'b0001, 8'h80);
        expect_wr(4'b0100, 8'h90);
        drive_srcs();
        step();
        chk("s5_grant_after_reset", 32'(grant_o), 32'b0001);
        drain("s5", 20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
